// File: rtl/btn_gen_pkg.sv
//==============================================================================
// btn_gen_pkg: shared types and constants for the bouncy button generator.
// Revision: 1.0
//==============================================================================
`default_nettype none

package btn_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE           = 2'd0,
        ST_PRESS_BOUNCE   = 2'd1,
        ST_HOLD           = 2'd2,
        ST_RELEASE_BOUNCE = 2'd3
    } state_e;

    localparam logic [15:0] LFSR_SEED           = 16'hACE1;
    // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1
    localparam logic [15:0] LFSR_TAPS           = 16'h002D;
    localparam logic [23:0] HOLD_CYCLES_DEFAULT = 24'h600000;

endpackage

`default_nettype wire

// File: rtl/lfsr16.sv
//==============================================================================
// lfsr16: free-running 16-bit maximal-length Fibonacci LFSR.
// Revision: 1.0
//==============================================================================
`default_nettype none

module lfsr16
    import btn_gen_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = {^(lfsr_q & LFSR_TAPS), lfsr_q[15:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

`default_nettype wire

// File: rtl/btn_bounce_gen.sv
//==============================================================================
// btn_bounce_gen: emulates one bouncy press/hold/release of a raw button.
// Revision: 1.0
//==============================================================================
`default_nettype none

module btn_bounce_gen
    import btn_gen_pkg::*;
#(
    parameter int          N_BOUNCE    = 3,
    parameter int          GLITCH_W    = 4,
    parameter int          RANDOM      = 1,
    parameter logic [23:0] HOLD_CYCLES = HOLD_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic trig,
    output logic btn,
    output logic busy,
    output logic done
);

    localparam int                SEG_W        = GLITCH_W + 1;
    localparam logic [4:0]        LAST_SEG     = 5'(2 * N_BOUNCE);
    localparam logic [SEG_W-1:0]  FIXED_LEN_M1 = SEG_W'((1 << GLITCH_W) - 1);

    state_e             state_q, state_d;
    logic               btn_q, btn_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [SEG_W-1:0]   seg_cnt_q, seg_cnt_d;
    logic [4:0]         seg_idx_q, seg_idx_d;
    logic [23:0]        hold_cnt_q, hold_cnt_d;
    logic [15:0]        lfsr_q;
    logic [SEG_W-1:0]   seg_load;
    logic               lfsr_unused;

    lfsr16 u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_q)
    );

    assign lfsr_unused = ^lfsr_q;

    // Counter preload is length-1, so a zero LFSR nibble still gives a 1-cycle segment
    assign seg_load = (RANDOM != 0) ? {1'b0, lfsr_q[GLITCH_W-1:0]} : FIXED_LEN_M1;

    always_comb begin
        state_d    = state_q;
        btn_d      = btn_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        seg_cnt_d  = seg_cnt_q;
        seg_idx_d  = seg_idx_q;
        hold_cnt_d = hold_cnt_q;

        case (state_q)
            ST_IDLE: begin
                btn_d  = 1'b0;
                busy_d = 1'b0;
                if (trig) begin
                    state_d   = ST_PRESS_BOUNCE;
                    btn_d     = 1'b1;
                    busy_d    = 1'b1;
                    seg_cnt_d = seg_load;
                    seg_idx_d = 5'd0;
                end
            end
            ST_PRESS_BOUNCE: begin
                if (seg_cnt_q != '0) begin
                    seg_cnt_d = seg_cnt_q - 1'b1;
                end else if (seg_idx_q == LAST_SEG) begin
                    state_d    = ST_HOLD;
                    btn_d      = 1'b1;
                    hold_cnt_d = HOLD_CYCLES - 24'd1;
                end else begin
                    seg_idx_d = seg_idx_q + 5'd1;
                    btn_d     = ~btn_q;
                    seg_cnt_d = seg_load;
                end
            end
            ST_HOLD: begin
                if (hold_cnt_q != 24'd0) begin
                    hold_cnt_d = hold_cnt_q - 24'd1;
                end else begin
                    state_d   = ST_RELEASE_BOUNCE;
                    btn_d     = 1'b0;
                    seg_cnt_d = seg_load;
                    seg_idx_d = 5'd0;
                end
            end
            ST_RELEASE_BOUNCE: begin
                if (seg_cnt_q != '0) begin
                    seg_cnt_d = seg_cnt_q - 1'b1;
                end else if (seg_idx_q == LAST_SEG) begin
                    state_d   = ST_IDLE;
                    btn_d     = 1'b0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    seg_idx_d = 5'd0;
                end else begin
                    seg_idx_d = seg_idx_q + 5'd1;
                    btn_d     = ~btn_q;
                    seg_cnt_d = seg_load;
                end
            end
            default: begin
                state_d = ST_IDLE;
                btn_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            btn_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            seg_cnt_q  <= '0;
            seg_idx_q  <= 5'd0;
            hold_cnt_q <= 24'd0;
        end else begin
            state_q    <= state_d;
            btn_q      <= btn_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            seg_cnt_q  <= seg_cnt_d;
            seg_idx_q  <= seg_idx_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign btn  = btn_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_btn_bounce_gen.sv
//==============================================================================
// tb_btn_bounce_gen: fixed-length and LFSR-driven instances against a
// waveform model built from segment lengths.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_btn_bounce_gen;

    localparam int LF_N = 65536;
    localparam int HOLD = 10;
    localparam int NB   = 2;

    logic clk;
    logic rst;
    logic trig0, trig1;
    logic btn0, busy0, done0;
    logic btn1, busy1, done1;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [15:0] lf [0:LF_N-1];
    logic [2:0]  q0 [$];
    logic [2:0]  q1 [$];
    logic [2:0]  h0 [0:255];
    logic [2:0]  h1 [0:255];

    btn_bounce_gen #(
        .N_BOUNCE    (NB),
        .GLITCH_W    (2),
        .RANDOM      (0),
        .HOLD_CYCLES (24'(HOLD))
    ) u_fix (
        .clk  (clk),
        .rst  (rst),
        .trig (trig0),
        .btn  (btn0),
        .busy (busy0),
        .done (done0)
    );

    btn_bounce_gen #(
        .N_BOUNCE    (NB),
        .GLITCH_W    (4),
        .RANDOM      (1),
        .HOLD_CYCLES (24'(HOLD))
    ) u_rnd (
        .clk  (clk),
        .rst  (rst),
        .trig (trig1),
        .btn  (btn1),
        .busy (busy1),
        .done (done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // LFSR value seen during cycle t after reset release
    function automatic int seg_len(input int rnd, input int w, input int t);
        if (t >= LF_N) return 1;
        if (rnd != 0) return 1 + int'(lf[t] & 16'((1 << w) - 1));
        return 1 << w;
    endfunction

    task automatic push(input int i, input logic [2:0] e);
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Expected {btn,busy,done} for every cycle after a trig accepted in cycle c
    task automatic gen(input int i, input int c);
        int w, rnd, t, len;
        w   = (i == 0) ? 2 : 4;
        rnd = (i == 0) ? 0 : 1;
        t   = c;
        for (int k = 0; k < 2 * NB + 1; k++) begin
            len = seg_len(rnd, w, t);
            for (int j = 0; j < len; j++) push(i, {(k % 2 == 0), 1'b1, 1'b0});
            t += len;
        end
        for (int j = 0; j < HOLD; j++) push(i, 3'b110);
        t += HOLD;
        for (int k = 0; k < 2 * NB + 1; k++) begin
            len = seg_len(rnd, w, t);
            for (int j = 0; j < len; j++) push(i, {(k % 2 == 1), 1'b1, 1'b0});
            t += len;
        end
        push(i, 3'b001);
    endtask

    initial begin
        logic [15:0] v;
        logic        b;
        v = 16'hACE1;
        for (int t = 0; t < LF_N; t++) begin
            lf[t] = v;
            b = v[0] ^ v[2] ^ v[3] ^ v[5];
            v = (v >> 1) | (16'(b) << 15);
        end
    end

    always @(negedge clk) begin
        logic [2:0] e;
        if (rst) begin
            q0.delete();
            q1.delete();
            cyc = 0;
        end else begin
            e = 3'b000;
            if (q0.size() > 0) e = q0.pop_front();
            chk($sformatf("fix_out@%0d", cyc), int'({btn0, busy0, done0}), int'(e));
            if (q0.size() == 0 && trig0) gen(0, cyc);

            e = 3'b000;
            if (q1.size() > 0) e = q1.pop_front();
            chk($sformatf("rnd_out@%0d", cyc), int'({btn1, busy1, done1}), int'(e));
            if (q1.size() == 0 && trig1) gen(1, cyc);

            chk($sformatf("lfsr_nonzero@%0d", cyc), int'(u_rnd.lfsr_q != 16'h0), 1);
            if (cyc < 256) begin
                h0[cyc] = {btn0, busy0, done0};
                h1[cyc] = {btn1, busy1, done1};
            end
            cyc++;
        end
    end

    initial begin
        rst   = 1'b1;
        trig0 = 1'b0;
        trig1 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Basic waveform, ignored trigs mid-sequence, retrigger on done cycle
        for (int c = 0; c < 115; c++) begin
            trig0 = (c == 0 || c == 7 || c == 40 || c == 51);
            trig1 = (c == 0);
            @(posedge clk);
            #1;
        end
        trig0 = 1'b0;
        trig1 = 1'b0;

        chk("model_lf1", int'(lf[1]), 32'h5670);
        chk("model_lf2", int'(lf[2]), 32'hAB38);
        chk("fix_btn_c4",   int'(h0[4][2]),  1);
        chk("fix_btn_c5",   int'(h0[5][2]),  0);
        chk("fix_btn_c17",  int'(h0[17][2]), 1);
        chk("fix_btn_c30",  int'(h0[30][2]), 1);
        chk("fix_btn_c31",  int'(h0[31][2]), 0);
        chk("fix_btn_c35",  int'(h0[35][2]), 1);
        chk("fix_btn_c50",  int'(h0[50][2]), 0);
        chk("fix_busy_c50", int'(h0[50][1]), 1);
        chk("fix_done_c51", int'(h0[51]),    1);
        chk("fix_btn_c52",  int'(h0[52][2]), 1);
        chk("rnd_btn_c2",   int'(h1[2][2]),  1);
        chk("rnd_btn_c3",   int'(h1[3][2]),  0);
        chk("rnd_btn_c11",  int'(h1[11][2]), 0);
        chk("rnd_btn_c12",  int'(h1[12][2]), 1);

        // Reset during HOLD, then a fresh sequence
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 25; c++) begin
            trig0 = (c == 0);
            @(posedge clk);
            #1;
        end
        trig0 = 1'b0;
        rst = 1'b1;
        #1;
        chk("abort_btn",  int'(btn0),  0);
        chk("abort_busy", int'(busy0), 0);
        chk("abort_done", int'(done0), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 60; c++) begin
            trig0 = (c == 0);
            @(posedge clk);
            #1;
        end
        trig0 = 1'b0;
        chk("rerun_done_c51", int'(h0[51]), 1);
        chk("rerun_btn_c1",   int'(h0[1][2]), 1);

        // Long random run, includes back-to-back and idle gaps
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            trig0 = ($urandom_range(0, 7) == 0);
            trig1 = ($urandom_range(0, 3) == 0);
            @(posedge clk);
            #1;
        end
        trig0 = 1'b0;
        trig1 = 1'b0;
        @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
